// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame constants and parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_ERROR     = 3'd6
    } ps2_tx_state_e;

    localparam int unsigned PS2_DATA_BITS = 8;
    localparam int unsigned PS2_STOP_IDX  = 10;
    localparam int unsigned PS2_BITCNT_W  = 4;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS2_CLK / PS2_DAT pins with falling-edge detect on each line.
module ps2_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_async,
    input  logic dat_async,
    output logic clk_s,
    output logic dat_s,
    output logic clk_fall_c,
    output logic dat_fall_c
);

    logic clk_meta;
    logic dat_meta;
    logic clk_prev;
    logic dat_prev;

    // Reset to the idle-high bus level so release of reset never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta <= 1'b1;
            dat_meta <= 1'b1;
            clk_s    <= 1'b1;
            dat_s    <= 1'b1;
            clk_prev <= 1'b1;
            dat_prev <= 1'b1;
        end else begin
            clk_meta <= clk_async;
            dat_meta <= dat_async;
            clk_s    <= clk_meta;
            dat_s    <= dat_meta;
            clk_prev <= clk_s;
            dat_prev <= dat_s;
        end
    end

    assign clk_fall_c = clk_prev & ~clk_s;
    assign dat_fall_c = dat_prev & ~dat_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Optional build macro PS2_TX_RETRY_EN adds automatic retry on NACK/timeout (MAX_RETRY attempts).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned BIT_TIMEOUT    = 100000
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY      = 2
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_async,
    input  logic       ps2_data_async,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned T_MAX_SB = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int unsigned T_MAX    = (T_MAX_SB > INHIBIT_CYCLES) ? T_MAX_SB : INHIBIT_CYCLES;
    localparam int unsigned TIMER_W  = $clog2(T_MAX + 1);

    localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] INH_START  = TIMER_W'(INHIBIT_CYCLES - 2);
    localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BIT_LAST   = TIMER_W'(BIT_TIMEOUT - 1);

    localparam logic [PS2_BITCNT_W-1:0] DATA_BITS_C = PS2_BITCNT_W'(PS2_DATA_BITS);
    localparam logic [PS2_BITCNT_W-1:0] STOP_IDX_C  = PS2_BITCNT_W'(PS2_STOP_IDX);

`ifdef PS2_TX_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic [RETRY_W-1:0] retry_cnt_q;
    logic [RETRY_W-1:0] retry_cnt_n;
`endif

    ps2_tx_state_e             state_q;
    ps2_tx_state_e             state_n;
    logic [TIMER_W-1:0]        timer_q;
    logic [TIMER_W-1:0]        timer_n;
    logic [PS2_BITCNT_W-1:0]   bitcnt_q;
    logic [PS2_BITCNT_W-1:0]   bitcnt_n;
    logic [PS2_DATA_BITS-1:0]  shreg_q;
    logic [PS2_DATA_BITS-1:0]  shreg_n;
    logic                      parity_q;
    logic                      parity_n;
    logic                      clk_oe_q;
    logic                      clk_oe_n;
    logic                      dat_oe_q;
    logic                      dat_oe_n;
    logic                      done_q;
    logic                      done_n;
    logic                      error_q;
    logic                      error_n;
    logic                      ready_q;
    logic                      busy_q;
    logic                      fail_c;

    logic clk_s;
    logic dat_s;
    logic clk_fall_c;
    logic dat_fall_unused;

    ps2_line_sync u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_async  (ps2_clk_async),
        .dat_async  (ps2_data_async),
        .clk_s      (clk_s),
        .dat_s      (dat_s),
        .clk_fall_c (clk_fall_c),
        .dat_fall_c (dat_fall_unused)
    );

    // Next-state and next-output logic; every register holds unless a branch overrides it.
    always_comb begin
        state_n  = state_q;
        timer_n  = timer_q;
        bitcnt_n = bitcnt_q;
        shreg_n  = shreg_q;
        parity_n = parity_q;
        clk_oe_n = clk_oe_q;
        dat_oe_n = dat_oe_q;
        done_n   = 1'b0;
        error_n  = 1'b0;
        fail_c   = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_cnt_n = retry_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shreg_n  = tx_data;
                    parity_n = odd_parity(tx_data);
                    timer_n  = '0;
                    bitcnt_n = '0;
                    clk_oe_n = 1'b1;
                    dat_oe_n = 1'b0;
                    state_n  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_cnt_n = '0;
`endif
                end
            end

            // Hold the clock low; the start bit goes down one cycle before the clock is released.
            S_INHIBIT: begin
                timer_n = timer_q + TIMER_W'(1);
                if (timer_q == INH_LAST) begin
                    timer_n  = '0;
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b1;
                    state_n  = S_START;
                end else if (timer_q == INH_START) begin
                    dat_oe_n = 1'b1;
                end
            end

            S_START: begin
                timer_n = timer_q + TIMER_W'(1);
                if (clk_fall_c) begin
                    timer_n  = '0;
                    dat_oe_n = ~shreg_q[0];
                    bitcnt_n = PS2_BITCNT_W'(1);
                    state_n  = S_DATA;
                end else if (timer_q == START_LAST) begin
                    fail_c = 1'b1;
                end
            end

            // Each device falling edge presents the next bit: data LSB first, parity, then stop.
            S_DATA: begin
                timer_n = timer_q + TIMER_W'(1);
                if (clk_fall_c) begin
                    timer_n  = '0;
                    bitcnt_n = bitcnt_q + PS2_BITCNT_W'(1);
                    if (bitcnt_q < DATA_BITS_C) begin
                        dat_oe_n = ~shreg_q[bitcnt_q[2:0]];
                    end else if (bitcnt_q == DATA_BITS_C) begin
                        dat_oe_n = ~parity_q;
                    end else begin
                        dat_oe_n = 1'b0;
                        bitcnt_n = STOP_IDX_C;
                        state_n  = S_ACK;
                    end
                end else if (timer_q == BIT_LAST) begin
                    fail_c = 1'b1;
                end
            end

            S_ACK: begin
                timer_n = timer_q + TIMER_W'(1);
                if (clk_fall_c) begin
                    timer_n = '0;
                    if (!dat_s) begin
                        state_n = S_WAIT_IDLE;
                    end else begin
                        fail_c = 1'b1;
                    end
                end else if (timer_q == BIT_LAST) begin
                    fail_c = 1'b1;
                end
            end

            // Done is raised while still here so tx_ready only rises after the pulse.
            S_WAIT_IDLE: begin
                if (done_q) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer_q + TIMER_W'(1);
                    if (clk_s && dat_s) begin
                        done_n = 1'b1;
                    end else if (clk_fall_c) begin
                        timer_n = '0;
                    end else if (timer_q == BIT_LAST) begin
                        fail_c = 1'b1;
                    end
                end
            end

            S_ERROR: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                state_n  = S_IDLE;
`ifdef PS2_TX_RETRY_EN
                if (retry_cnt_q < RETRY_LIMIT) begin
                    retry_cnt_n = retry_cnt_q + RETRY_W'(1);
                    timer_n     = '0;
                    bitcnt_n    = '0;
                    clk_oe_n    = 1'b1;
                    state_n     = S_INHIBIT;
                end
`endif
            end

            default: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                state_n  = S_IDLE;
            end
        endcase

        // Any NACK or timeout releases both lines on entry to ERROR.
        if (fail_c) begin
            state_n  = S_ERROR;
            timer_n  = '0;
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
`ifdef PS2_TX_RETRY_EN
            error_n  = (retry_cnt_q >= RETRY_LIMIT);
`else
            error_n  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            timer_q  <= timer_n;
            bitcnt_q <= bitcnt_n;
            shreg_q  <= shreg_n;
            parity_q <= parity_n;
            clk_oe_q <= clk_oe_n;
            dat_oe_q <= dat_oe_n;
            done_q   <= done_n;
            error_q  <= error_n;
            ready_q  <= (state_n == S_IDLE);
            busy_q   <= (state_n != S_IDLE);
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retry_cnt_q <= '0;
        end else begin
            retry_cnt_q <= retry_cnt_n;
        end
    end
`endif

    assign tx_ready   = ready_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    assign busy       = busy_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on open-drain lines, expected-response queue and monitor.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int unsigned INH  = 50;
    localparam int unsigned STO  = 750;
    localparam int unsigned BTO  = 200;
    localparam int          HALF = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int ERR_PHASES = 3;
`else
    localparam int ERR_PHASES = 1;
`endif

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;
    logic       ps2_clk_async;
    logic       ps2_data_async;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    int         dev_mode = 0;      // 0: ACK, 1: never clocks, 2: NACK
    logic       dev_busy = 1'b0;
    int         dev_bits = 0;
    logic [9:0] dev_frame = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int inh_run = 0;
    int inh_count = 0;
    int last_rel = 0;

    typedef struct {
        logic       is_done;
        logic [9:0] frame;
        logic       chk_frame;
        int         phases;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .BIT_TIMEOUT    (BTO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_done        (tx_done),
        .tx_error       (tx_error),
        .busy           (busy),
        .ps2_clk_async  (ps2_clk_async),
        .ps2_data_async (ps2_data_async),
        .ps2_clk_oe     (ps2_clk_oe),
        .ps2_dat_oe     (ps2_dat_oe)
    );

    // Open-drain wiring: either side can pull a line low.
    assign ps2_clk_async  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_async = dev_dat & ~ps2_dat_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait expired at cycle %0d", name, cyc);
    endtask

    // Inhibit watcher: length of each clk_oe low-pull and the cycle of each release.
    always @(negedge clk) begin
        if (!reset_n) begin
            inh_run = 0;
        end else if (ps2_clk_oe) begin
            inh_run++;
        end else if (inh_run != 0) begin
            check("inhibit_len", 32'(inh_run), 32'(INH));
            inh_count++;
            last_rel = cyc;
            inh_run  = 0;
        end
    end

    // Monitor: every done/error cycle consumes one expected response.
    always @(negedge clk) begin
        if (reset_n && (tx_done || tx_error)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse done=%0b error=%0b at cycle %0d", tx_done, tx_error, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", {30'd0, tx_done, tx_error}, mon_e.is_done ? 32'd2 : 32'd1);
                check("ready_low_at_pulse", 32'(tx_ready), 32'd0);
                if (mon_e.chk_frame) check("frame_bits", 32'(dev_frame), 32'(mon_e.frame));
                check("inhibit_phases", 32'(inh_count), 32'(mon_e.phases));
                inh_count = 0;
            end
        end
    end

    // Device model: clocks out the frame, samples data on each rising edge, then ACKs or NACKs.
    initial begin
        forever begin
            @(negedge clk);
            if (dev_mode != 1 && !dev_busy && ps2_clk_async && !ps2_data_async) begin
                dev_busy = 1'b1;
                dev_bits = 0;
                repeat (10) @(negedge clk);
                for (int i = 0; i < 10; i++) begin
                    dev_clk = 1'b0;
                    repeat (HALF) @(negedge clk);
                    dev_clk = 1'b1;
                    dev_frame[i] = ps2_data_async;
                    dev_bits = i + 1;
                    repeat (HALF) @(negedge clk);
                end
                if (dev_mode == 0) dev_dat = 1'b0;
                repeat (5) @(negedge clk);
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk);
                dev_clk = 1'b1;
                repeat (5) @(negedge clk);
                dev_dat  = 1'b1;
                dev_busy = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int n;
        for (n = 0; n < 5000; n++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        if (n == 5000) timeout_fail("wait_ready");
    endtask

    task automatic push_exp(input logic is_done, input logic [9:0] frame, input logic chk, input int phases);
        exp_t e;
        e.is_done   = is_done;
        e.frame     = frame;
        e.chk_frame = chk;
        e.phases    = phases;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [7:0] b, input logic is_done, input logic [9:0] frame,
                         input logic chk, input int phases);
        push_exp(is_done, frame, chk, phases);
        wait_ready();
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !dev_busy) break;
        end
        if (n == budget) begin
            timeout_fail("drain");
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(tx_ready), 32'd1);

        // Normal frames with hand-computed {stop, parity, data}.
        issue(8'hED, 1'b1, 10'h3ED, 1'b1, 1);
        drain(3000);
        issue(8'h00, 1'b1, 10'h300, 1'b1, 1);
        drain(3000);
        issue(8'h01, 1'b1, 10'h201, 1'b1, 1);
        drain(3000);

        // Device never clocks: start timeout measured from the last clock release.
        dev_mode = 1;
        issue(8'hF4, 1'b0, 10'h000, 1'b0, ERR_PHASES);
        for (n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (tx_error) break;
        end
        if (n == 4000) begin
            timeout_fail("start_timeout_pulse");
        end else begin
            check("start_timeout_latency", 32'(cyc - last_rel), 32'(STO));
            @(negedge clk);
            check("post_err_clk_oe", 32'(ps2_clk_oe), 32'd0);
            check("post_err_dat_oe", 32'(ps2_dat_oe), 32'd0);
            check("post_err_ready", 32'(tx_ready), 32'd1);
        end
        drain(100);
        dev_mode = 0;

        // Device NACKs.
        dev_mode = 2;
        issue(8'hFF, 1'b0, 10'h3FF, 1'b1, ERR_PHASES);
        drain(6000);
        dev_mode = 0;

        // Reset pulsed mid-DATA after bit 4; bit 4 of 0x0F is 0 so data is being pulled.
        wait_ready();
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (dev_bits >= 5 && dev_busy) break;
        end
        if (n == 3000) timeout_fail("reach_bit4");
        check("dat_oe_before_reset", 32'(ps2_dat_oe), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("async_rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("async_rst_ready", 32'(tx_ready), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!dev_busy) break;
        end
        if (n == 3000) timeout_fail("device_abort");
        repeat (5) @(negedge clk);
        inh_count = 0;
        issue(8'hF4, 1'b1, 10'h2F4, 1'b1, 1);
        drain(3000);

        // tx_valid held high while the byte changes: 0xAA first, 0x55 only after tx_ready returns.
        push_exp(1'b1, 10'h3AA, 1'b1, 1);
        push_exp(1'b1, 10'h355, 1'b1, 1);
        wait_ready();
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!tx_ready) break;
        end
        tx_data = 8'h55;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (tx_ready) break;
        end
        if (n == 3000) timeout_fail("ready_return");
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!tx_ready) break;
        end
        tx_valid = 1'b0;
        drain(4000);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter, the reverse direction of the existing PS/2 receive path.
- Sends one command byte to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- Drives the open-drain PS2_CLK/PS2_DAT lines through active-high pull-low enables.
- Sits beside ps2_decoder on CLOCK_50 and asserts busy so the decoder ignores its own frame.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit time before start (100 us at 50 MHz).
- START_TIMEOUT, 750000: max cycles from clock release to first device falling edge (15 ms).
- BIT_TIMEOUT, 100000: max cycles between consecutive device falling edges, and for the final idle wait (2 ms).
- MAX_RETRY, 2: retries on NACK or timeout (used only when PS2_TX_RETRY_EN is defined).

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE.
- tx_done  out  1  1-cycle pulse: frame acknowledged by device.
- tx_error  out  1  1-cycle pulse: NACK or timeout.
- busy  out  1  high in every state except IDLE.
- ps2_clk_async  in  1  raw PS2_CLK pin.
- ps2_data_async  in  1  raw PS2_DAT pin.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; tx_ready=1; tx_done=0; tx_error=0; busy=0; ps2_clk_oe=0; ps2_dat_oe=0; counters=0. A reset mid-frame releases both lines at once; no done/error pulse is generated.
- Input synchronisation: each pin goes through a 2-flop synchroniser. fall = prev_clk_s & ~clk_s. Pin-to-fall latency is 3 clk.
- Accept: a transfer is accepted when tx_valid & tx_ready. On the accept edge, latch tx_data into shreg, compute parity = ~^tx_data (odd parity), and go to INHIBIT. tx_valid outside IDLE is ignored.
- INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0. Count INHIBIT_CYCLES. On the last cycle set ps2_dat_oe=1 (start bit), then go to START.
- START: ps2_clk_oe=0, ps2_dat_oe=1, timer counts.
  - First fall: drive bit0, bitcnt=1, go to DATA.
  - Timer reaches START_TIMEOUT: go to ERROR.
- DATA: on each fall, drive data bit bitcnt (LSB first); ps2_dat_oe = ~bit. Once bitcnt reaches 8, the next fall drives parity (bitcnt=9), and the fall after that releases data (stop, bitcnt=10). Then go to ACK.
- ACK: on the next fall, sample dat_s. 0 means ACK and goes to WAIT_IDLE; 1 means NACK and goes to ERROR.
- WAIT_IDLE: wait for clk_s=1 & dat_s=1, then pulse tx_done and go to IDLE.
- Timeout: the timer reloads on every fall. Reaching BIT_TIMEOUT in DATA, ACK or WAIT_IDLE goes to ERROR.
- ERROR (1 cycle): release both lines, pulse tx_error, go to IDLE.
- Minimum IDLE dwell between frames is 1 cycle. tx_ready rises in the cycle after the done/error pulse.
- tx_done and tx_error are never high together.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: ERROR reloads the latched byte and returns to INHIBIT while retry_cnt < MAX_RETRY, and increments retry_cnt. tx_error pulses only after the final failure. retry_cnt clears on accept.
- Undefined: no retry counter; every failure pulses tx_error and returns to IDLE.

Decomposition:
- Package ps2_pkg: state encoding (IDLE, INHIBIT, START, DATA, ACK, WAIT_IDLE, ERROR), and frame constants PS2_DATA_BITS=8, PS2_STOP_IDX=10.
- Sub-module ps2_line_sync: 2-flop synchroniser plus falling-edge detect for clk and data. Reusable by ps2_decoder.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz, checks the data bit on each rising edge and ACKs. Required: bits 1,0,1,1,0,1,1,1, parity 1, stop 1; clk_oe held low for exactly 5000 cycles; tx_done pulses once.
- Send 0x00: parity bit=1. Send 0x01: parity bit=0. Both complete with tx_done.
- Device never clocks: tx_error pulses 750000 cycles after clock release. Both oe=0 and tx_ready=1 on the following cycle.
- Device leaves data high at the ACK fall: tx_error pulses and tx_done stays 0. With PS2_TX_RETRY_EN, the bench sees 3 inhibit phases before a single tx_error.
- reset_n pulsed low mid-DATA (after bit 4): ps2_clk_oe and ps2_dat_oe go to 0 asynchronously, no pulse fires, and the next 0xF4 request completes normally.
- tx_valid held high during a frame carrying a different byte: only the first byte is sent, and the second is accepted only after tx_ready returns.
